ysyx_22041211_idu_stage: RTL
============================

// Module: ysyx_22041211_idu_stage
// PURPOSE
//   RV32I decode stage directly downstream of the fetch unit. Accepts {pc, inst} over valid/ready.
//   Decodes the instruction into operand indices, a sign-extended immediate and control fields.
//   Holds the result in a one-entry pipeline register and presents it to the execute stage over valid/ready.
//   Supports flush on branch/jump/trap redirect.
// PARAMETERS
//   ADDR_WIDTH  32  pc width
//   DATA_WIDTH  32  instruction/immediate width
// PORTS
//   clk            in   1   single clock, rising edge
//   rst            in   1   asynchronous, active-low reset (0 = reset)
//   in_valid       in   1   fetch presents a valid {in_pc, in_inst}
//   in_ready       out  1   stage can accept this cycle
//   in_pc          in   32  pc of fetched instruction
//   in_inst        in   32  fetched instruction word
//   flush_i        in   1   redirect: kill held entry and incoming beat
//   out_valid      out  1   decoded entry valid toward execute
//   out_ready      in   1   execute consumes entry this cycle
//   out_pc         out  32  pc of decoded instruction
//   out_imm        out  32  sign-extended immediate (I/S/B/U/J per format; 0 for R)
//   out_rs1        out  5   source register 1 index
//   out_rs2        out  5   source register 2 index
//   out_rd         out  5   destination register index
//   out_rd_wen     out  1   writes rd (forced 0 when rd==0)
//   out_kind       out  4   instruction class (package enum)
//   out_alu_op     out  4   ALU operation (package enum)
//   out_src_a_pc   out  1   ALU operand A = pc (AUIPC/JAL/JALR link), else rs1
//   out_src_b_imm  out  1   ALU operand B = imm, else rs2
//   out_funct3     out  3   raw funct3 (branch condition / mem width / CSR op)
// BEHAVIOUR
//   - Reset (rst=0, async): out_valid=0; all other out_* registers = 0. in_ready=1 once rst=1.
//   - in_ready = !out_valid | out_ready (combinational). Full throughput: one beat per cycle.
//   - Accept: in_valid & in_ready & !flush_i. Decode is combinational on in_inst.
//     Result registered at that edge. Latency 1 cycle, in -> out_valid.
//   - Hold: while out_valid & !out_ready, every out_* stays bit-stable.
//   - Drain: out_ready & out_valid & no accept -> out_valid<=0.
//   - Flush (highest priority): out_valid<=0 next edge. in_ready=1 during flush;
//     any incoming beat is consumed and discarded. Data registers need not change.
//   - Flush with rst=0: reset wins.
//   - Kinds: ALU(OP/OP-IMM/LUI/AUIPC), LOAD, STORE, BRANCH, JAL, JALR, CSR, SYSTEM(ecall/ebreak/mret), FENCE(nop), ILLEGAL.
//   - ILLEGAL when any of: inst[1:0]!=2'b11; unknown opcode; branch f3 in {010,011};
//     load f3 in {011,110,111}; store f3>=011; OP f7 not 0000000/0100000 (0100000 only for ADD/SRA);
//     slli/srli/srai bad imm[11:5]. For ILLEGAL: out_rd_wen=0, out_imm=0.
//   - ALU mapping:
//     - LUI -> PASS_B.
//     - AUIPC/JAL/JALR -> ADD; JAL/JALR use src_a_pc=1, src_b_imm=0, with execute adding 4 for link.
//     - LOAD/STORE -> ADD with imm.
//     - BRANCH -> SUB/SLT/SLTU per f3.
//   - out_rd_wen=0 for STORE/BRANCH/FENCE/SYSTEM. Shift imm = zero-extended shamt.
// STRUCTURE
//   - Package ysyx_22041211_idu_pkg:
//     - opcode localparams.
//     - KIND enum: ALU=0, LOAD=1, STORE=2, BRANCH=3, JAL=4, JALR=5, CSR=6, SYSTEM=7, FENCE=8, ILLEGAL=15.
//     - ALU enum: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS_B=10.
//   - Sub-module ysyx_22041211_imm_gen: combinational, inst + format -> 32-bit sign-extended imm.
//   - Top: combinational decoder plus the one-entry output register with the handshake/flush logic.
// TESTING
//   1. 0x00500093 (addi x1,x0,5) @pc 0x80000000, out_ready=1
//      -> next cycle out_valid=1, kind ALU, rd=1, rs1=0, imm=5, alu ADD, src_b_imm=1, rd_wen=1.
//   2. 0xFE208CE3 (beq x1,x2,-8)
//      -> kind BRANCH, rs1=1, rs2=2, imm=0xFFFFFFF8, alu SUB, funct3=000, rd_wen=0.
//   3. 0x123452B7 (lui x5,0x12345) -> imm=0x12345000, alu PASS_B, rd=5.
//      0x00000000 -> kind ILLEGAL, rd_wen=0.
//   4. Stream 3 beats; hold out_ready=0 for 3 cycles
//      -> in_ready=0 and out_* stable throughout.
//      Release -> held beat drains and next beat accepted same edge; no loss or duplication.
//   5. flush_i=1 with out_valid=1 and in_valid=1
//      -> in_ready=1, out_valid=0 next cycle, the incoming beat never appears at the output.
//   6. Drive rst=0 between clock edges while out_valid=1
//      -> out_valid=0 immediately (before next edge); after release, first beat has latency 1.

Source files
------------

// File: rtl/ysyx_22041211_idu_pkg.sv
// Shared RV32I decode definitions: opcodes, instruction classes, ALU operations
// and immediate formats used by the decode stage and its immediate generator.
package ysyx_22041211_idu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    KIND_ALU     = 4'd0,
    KIND_LOAD    = 4'd1,
    KIND_STORE   = 4'd2,
    KIND_BRANCH  = 4'd3,
    KIND_JAL     = 4'd4,
    KIND_JALR    = 4'd5,
    KIND_CSR     = 4'd6,
    KIND_SYSTEM  = 4'd7,
    KIND_FENCE   = 4'd8,
    KIND_ILLEGAL = 4'd15
  } kind_e;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_e;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SHAMT
  } imm_fmt_e;

  typedef struct packed {
    kind_e      kind;
    alu_e       alu_op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rd_wen;
    logic       src_a_pc;
    logic       src_b_imm;
    logic [2:0] funct3;
  } dec_t;

  // alt selects SUB/SRA; callers only raise it where the encoding allows it
  function automatic alu_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ysyx_22041211_imm_gen.sv
// Combinational immediate extraction: instruction bits [31:7] plus format
// select produce the 32-bit sign-extended (or zero-extended shamt) immediate.
module ysyx_22041211_imm_gen
  import ysyx_22041211_idu_pkg::*;
(
  input  logic [31:7] inst,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:     imm = {{20{inst[31]}}, inst[31:20]};
      FMT_S:     imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:     imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:     imm = {inst[31:12], 12'b0};
      FMT_J:     imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      FMT_SHAMT: imm = {27'b0, inst[24:20]};
      default:   imm = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22041211_idu_stage.sv
// RV32I decode stage: combinational decode of the fetched word feeding a
// one-entry output register with valid/ready handshake and redirect flush.
module ysyx_22041211_idu_stage
  import ysyx_22041211_idu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_inst,
  input  logic                  flush_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [4:0]            out_rs1,
  output logic [4:0]            out_rs2,
  output logic [4:0]            out_rd,
  output logic                  out_rd_wen,
  output logic [3:0]            out_kind,
  output logic [3:0]            out_alu_op,
  output logic                  out_src_a_pc,
  output logic                  out_src_b_imm,
  output logic [2:0]            out_funct3
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  assign opcode = in_inst[6:0];
  assign f3     = in_inst[14:12];
  assign f7     = in_inst[31:25];
  assign rd     = in_inst[11:7];

  kind_e       kind;
  alu_e        alu_op;
  imm_fmt_e    fmt;
  logic        src_a_pc;
  logic        src_b_imm;
  logic        writes_rd;
  logic [31:0] imm_raw;
  dec_t        dec_next;
  logic [31:0] imm_next;

  always_comb begin
    kind      = KIND_ILLEGAL;
    alu_op    = ALU_ADD;
    fmt       = FMT_R;
    src_a_pc  = 1'b0;
    src_b_imm = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OPC_LUI: begin
        kind = KIND_ALU; alu_op = ALU_PASS_B; fmt = FMT_U; src_b_imm = 1'b1; writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        kind = KIND_ALU; fmt = FMT_U; src_a_pc = 1'b1; src_b_imm = 1'b1; writes_rd = 1'b1;
      end
      // jumps compute pc + 4 for the link value; execute supplies the constant
      OPC_JAL: begin
        kind = KIND_JAL; fmt = FMT_J; src_a_pc = 1'b1; writes_rd = 1'b1;
      end
      OPC_JALR: if (f3 == 3'b000) begin
        kind = KIND_JALR; fmt = FMT_I; src_a_pc = 1'b1; writes_rd = 1'b1;
      end
      OPC_BRANCH: if (f3[2:1] != 2'b01) begin
        kind   = KIND_BRANCH; fmt = FMT_B;
        alu_op = !f3[2] ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
      end
      OPC_LOAD: if (f3 != 3'b011 && f3[2:1] != 2'b11) begin
        kind = KIND_LOAD; fmt = FMT_I; src_b_imm = 1'b1; writes_rd = 1'b1;
      end
      OPC_STORE: if (f3 < 3'b011) begin
        kind = KIND_STORE; fmt = FMT_S; src_b_imm = 1'b1;
      end
      OPC_OP_IMM: if ((f3 != 3'b001 || f7 == 7'b0000000) &&
                      (f3 != 3'b101 || f7 == 7'b0000000 || f7 == 7'b0100000)) begin
        kind      = KIND_ALU;
        fmt       = (f3[1:0] == 2'b01) ? FMT_SHAMT : FMT_I;
        alu_op    = alu_from_f3(f3, f3 == 3'b101 && in_inst[30]);
        src_b_imm = 1'b1; writes_rd = 1'b1;
      end
      OPC_OP: if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
        kind = KIND_ALU; alu_op = alu_from_f3(f3, in_inst[30]); writes_rd = 1'b1;
      end
      OPC_FENCE: if (f3[2:1] == 2'b00) kind = KIND_FENCE;
      OPC_SYSTEM: begin
        if (f3 == 3'b000) begin
          if (in_inst[31:7] == 25'h0 || in_inst[31:7] == 25'h2000 || in_inst[31:7] == 25'h604000) begin
            kind = KIND_SYSTEM; fmt = FMT_I;
          end
        end else if (f3 != 3'b100) begin
          kind = KIND_CSR; fmt = FMT_I; writes_rd = 1'b1;
        end
      end
      default: kind = KIND_ILLEGAL;
    endcase
  end

  ysyx_22041211_imm_gen u_imm_gen (
    .inst (in_inst[31:7]),
    .fmt  (fmt),
    .imm  (imm_raw)
  );

  always_comb begin
    dec_next.kind      = kind;
    dec_next.alu_op    = alu_op;
    dec_next.rs1       = in_inst[19:15];
    dec_next.rs2       = in_inst[24:20];
    dec_next.rd        = rd;
    dec_next.rd_wen    = writes_rd && (rd != 5'd0);
    dec_next.src_a_pc  = src_a_pc;
    dec_next.src_b_imm = src_b_imm;
    dec_next.funct3    = f3;
    imm_next           = (kind == KIND_ILLEGAL) ? 32'd0 : imm_raw;
  end

  logic                  valid_reg;
  logic [ADDR_WIDTH-1:0] pc_reg;
  logic [DATA_WIDTH-1:0] imm_reg;
  dec_t                  dec_reg;
  logic                  accept;

  assign in_ready = flush_i || !valid_reg || out_ready;
  assign accept   = in_valid && in_ready && !flush_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= 1'b0;
      pc_reg    <= '0;
      imm_reg   <= '0;
      dec_reg   <= '0;
    end else if (flush_i) begin
      valid_reg <= 1'b0;
    end else if (accept) begin
      valid_reg <= 1'b1;
      pc_reg    <= in_pc;
      imm_reg   <= imm_next;
      dec_reg   <= dec_next;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid     = valid_reg;
  assign out_pc        = pc_reg;
  assign out_imm       = imm_reg;
  assign out_rs1       = dec_reg.rs1;
  assign out_rs2       = dec_reg.rs2;
  assign out_rd        = dec_reg.rd;
  assign out_rd_wen    = dec_reg.rd_wen;
  assign out_kind      = dec_reg.kind;
  assign out_alu_op    = dec_reg.alu_op;
  assign out_src_a_pc  = dec_reg.src_a_pc;
  assign out_src_b_imm = dec_reg.src_b_imm;
  assign out_funct3    = dec_reg.funct3;

endmodule
